// File: rtl/cnn_layer_sequencer_pkg.sv
// cnn_layer_sequencer_pkg
//   Shared definitions for the CNN layer sequencer:
//   - DATA_LEN       : feature-map depth multiplier (bus width is 32*12*DATA_LEN)
//   - L_*            : cs_layer codes understood by cnn_layer
//   - sq_state_e     : 3-bit sequencer state encoding
//   - layer_tbl()    : fixed layer table, indexed by the layer counter; the last
//                      executed entry is always AFFINE
package cnn_layer_sequencer_pkg;

  localparam int DATA_LEN = 1;
  localparam int WD_W     = 12;

  localparam logic [3:0] L_CONV1  = 4'h1;
  localparam logic [3:0] L_POOL1  = 4'h2;
  localparam logic [3:0] L_CONV2  = 4'h3;
  localparam logic [3:0] L_POOL2  = 4'h4;
  localparam logic [3:0] L_CONV3  = 4'h5;
  localparam logic [3:0] L_POOL3  = 4'h6;
  localparam logic [3:0] L_AFFINE = 4'hF;

  typedef enum logic [2:0] {
    SQ_IDLE  = 3'd0,
    SQ_LOAD  = 3'd1,
    SQ_WAIT  = 3'd2,
    SQ_DRAIN = 3'd3,
    SQ_DONE  = 3'd4
  } sq_state_e;

  // Conv/pool pairs in order; deeper tables keep alternating CONV3/POOL3.
  function automatic logic [3:0] layer_tbl(input logic [3:0] idx, input logic [3:0] last_idx);
    logic [3:0] code;
    if (idx == last_idx) begin
      code = L_AFFINE;
    end else begin
      case (idx)
        4'd0:    code = L_CONV1;
        4'd1:    code = L_POOL1;
        4'd2:    code = L_CONV2;
        4'd3:    code = L_POOL2;
        4'd4:    code = L_CONV3;
        4'd5:    code = L_POOL3;
        default: code = idx[0] ? L_POOL3 : L_CONV3;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/layer_seq_fsm.sv
// layer_seq_fsm
//   Control half of the layer sequencer: state register, layer index counter,
//   registered layer_load/layer_sel/busy/done and (optionally) the WAIT watchdog.
//   Optional feature: define CNN_SEQ_TIMEOUT_EN to enable the watchdog and err.
// Ports
//   clk, rst        clock, async active-high reset
//   start, abort    run request / cancel
//   layer_valid     level valid from cnn_layer
//   load_q          registered load pulse (ungated by abort)
//   sel_q           registered cs_layer code
//   busy_q, done_q  registered status
//   err_q           sticky timeout flag (0 when watchdog disabled)
//   cap_img         buffer should take img_d this edge
//   cap_q           buffer should take layer_q this edge
module layer_seq_fsm
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = 4
`ifdef CNN_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT  = 4095
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       layer_valid,
  output logic       load_q,
  output logic [3:0] sel_q,
  output logic       busy_q,
  output logic       done_q,
  output logic       err_q,
  output logic       cap_img,
  output logic       cap_q
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_LAYERS - 1);

  sq_state_e  state_q;
  logic [3:0] idx_q;

  // Buffer strobes; abort always wins over a capture in the same cycle.
  assign cap_img = (state_q == SQ_IDLE) && start && !abort;
  assign cap_q   = (state_q == SQ_WAIT) && layer_valid && !abort;

`ifdef CNN_SEQ_TIMEOUT_EN
  // WAIT lasts at most TIMEOUT cycles; wd_q counts the WAIT cycles already spent.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q;
`else
  assign err_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SQ_IDLE;
      idx_q   <= '0;
      load_q  <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CNN_SEQ_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (abort && (state_q != SQ_IDLE)) begin
        // idx and sel keep their values; the next start reloads both.
        state_q <= SQ_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          SQ_IDLE: begin
            if (start && !abort) begin
              state_q <= SQ_LOAD;
              idx_q   <= '0;
              load_q  <= 1'b1;
              sel_q   <= layer_tbl(4'd0, LAST_IDX);
              busy_q  <= 1'b1;
`ifdef CNN_SEQ_TIMEOUT_EN
              err_q   <= 1'b0;
`endif
            end
          end
          SQ_LOAD: begin
            state_q <= SQ_WAIT;
`ifdef CNN_SEQ_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
          SQ_WAIT: begin
            if (layer_valid) begin
              state_q <= SQ_DRAIN;
            end
`ifdef CNN_SEQ_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
              state_q <= SQ_IDLE;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
`endif
          end
          SQ_DRAIN: begin
            // Hold off the next load until cnn_layer has dropped valid,
            // so a long valid is never captured twice.
            if (!layer_valid) begin
              if (idx_q == LAST_IDX) begin
                state_q <= SQ_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= SQ_LOAD;
                idx_q   <= idx_q + 4'd1;
                load_q  <= 1'b1;
                sel_q   <= layer_tbl(idx_q + 4'd1, LAST_IDX);
              end
            end
          end
          SQ_DONE: begin
            state_q <= SQ_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= SQ_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
//   Top-level layer scheduler: captures img_d on an accepted start, then runs
//   cnn_layer once per layer-table entry, feeding each q back as the next d.
//   The final (AFFINE) output is left in the buffer and flagged with done.
//   Optional feature: define CNN_SEQ_TIMEOUT_EN for the WAIT watchdog (err, TIMEOUT).
// Ports
//   clk, rst               clock, async active-high reset
//   start, abort           run request / cancel
//   img_d   [DATA_W]       input feature map
//   layer_valid, layer_q   cnn_layer result handshake
//   layer_load, layer_sel  cnn_layer launch and cs_layer code
//   layer_d [DATA_W]       cnn_layer input (the feedback buffer)
//   busy, done, result     run status and final output
//   err                    watchdog timeout (sticky)
module cnn_layer_sequencer
  import cnn_layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int DATA_W     = 32 * 12 * DATA_LEN
`ifdef CNN_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT  = 4095
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] img_d,
  input  logic              layer_valid,
  input  logic [DATA_W-1:0] layer_q,
  output logic              layer_load,
  output logic [3:0]        layer_sel,
  output logic [DATA_W-1:0] layer_d,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err
);

  logic              load_q;
  logic              cap_img;
  logic              cap_q;
  logic [DATA_W-1:0] fbuf_q;
  logic [DATA_W-1:0] fbuf_d;

  layer_seq_fsm #(
    .NUM_LAYERS (NUM_LAYERS)
`ifdef CNN_SEQ_TIMEOUT_EN
    , .TIMEOUT  (TIMEOUT)
`endif
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .layer_valid (layer_valid),
    .load_q      (load_q),
    .sel_q       (layer_sel),
    .busy_q      (busy),
    .done_q      (done),
    .err_q       (err),
    .cap_img     (cap_img),
    .cap_q       (cap_q)
  );

  // Feedback buffer: image on start, each layer result on capture, else hold.
  always_comb begin
    fbuf_d = fbuf_q;
    if (cap_img)    fbuf_d = img_d;
    else if (cap_q) fbuf_d = layer_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fbuf_q <= '0;
    else     fbuf_q <= fbuf_d;
  end

  // An abort landing in the LOAD cycle must not launch cnn_layer.
  assign layer_load = load_q & ~abort;
  assign layer_d    = fbuf_q;
  assign result     = fbuf_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
module tb_cnn_layer_sequencer;
  import cnn_layer_sequencer_pkg::*;

  localparam int NL = 4;
  localparam int DW = 32 * 12 * DATA_LEN;
  localparam int NE = DW / 32;
  localparam int BOUND = 300;

  logic          clk = 1'b0;
  logic          rst, start, abort, layer_valid;
  logic [DW-1:0] img_d, layer_q, layer_d, result;
  logic          layer_load, busy, done, err;
  logic [3:0]    layer_sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_LAYERS (NL),
    .DATA_W     (DW)
`ifdef CNN_SEQ_TIMEOUT_EN
    , .TIMEOUT  (20)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .img_d       (img_d),
    .layer_valid (layer_valid),
    .layer_q     (layer_q),
    .layer_load  (layer_load),
    .layer_sel   (layer_sel),
    .layer_d     (layer_d),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err         (err)
  );

  function automatic logic [DW-1:0] mk(input logic [31:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] plus1(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*32 +: 32] = d[i*32 +: 32] + 32'd1;
    return r;
  endfunction

  // cnn_layer stub: q=d+1 per element, valid 5 cycles after load, held hold_n cycles
  int            hold_n = 1;
  bit            never_valid = 1'b0;
  int            cnt = -1;
  int            hold_left = 0;
  logic [DW-1:0] d_lat;

  initial begin
    layer_valid = 1'b0;
    layer_q     = '0;
    d_lat       = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cnt = -1; hold_left = 0; layer_valid = 1'b0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) layer_valid = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            cnt = -1;
            if (!never_valid) begin
              layer_valid = 1'b1;
              layer_q     = plus1(d_lat);
              hold_left   = hold_n;
            end
          end
        end
        if (layer_load) begin
          cnt   = 5;
          d_lat = layer_d;
        end
      end
    end
  end

  // Monitor: load/done counts, sel log, valid-fall -> load spacing
  int         cyc = 0, loads = 0, dones = 0, gap_bad = 0, fall_cyc = -1;
  logic [3:0] sel_log [16];
  logic       v_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (v_prev && !layer_valid) fall_cyc = cyc;
      v_prev = layer_valid;
      if (!busy) fall_cyc = -1;
      if (layer_load) begin
        if (loads < 16) sel_log[loads] = layer_sel;
        loads++;
        if (fall_cyc >= 0 && cyc != fall_cyc + 1) gap_bad++;
        fall_cyc = -1;
      end
      if (done) begin
        dones++;
        fall_cyc = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic [31:0] exp_base);
    logic [DW-1:0] e;
    int            k;
    e = mk(exp_base);
    k = -1;
    for (int i = NE - 1; i >= 0; i--) if (result[i*32 +: 32] !== e[i*32 +: 32]) k = i;
    total++;
    if (k >= 0) begin
      bad++;
      $display("FAIL %s elem%0d got=%0h want=%0h", nm, k, result[k*32 +: 32], e[k*32 +: 32]);
    end
  endtask

  task automatic clr_mon();
    loads = 0; dones = 0; gap_bad = 0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < BOUND) begin tick(); n++; end
    chk(nm, 32'(n < BOUND), 32'd1);
  endtask

  // One complete run with full checking of the run's observable behaviour
  task automatic run_full(input string nm, input logic [31:0] base, input int hold,
                          input logic [31:0] exp_base);
    logic [3:0] exp_sel [NL];
    exp_sel = '{L_CONV1, L_POOL1, L_CONV2, L_AFFINE};
    clr_mon();
    hold_n = hold;
    img_d  = mk(base);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk({nm, "_load1"}, {30'd0, busy, layer_load}, 32'd3);
    wait_done({nm, "_done_to"});
    chk_res({nm, "_result"}, exp_base);
    tick();
    chk({nm, "_busy_after"}, {30'd0, busy, done}, 32'd0);
    chk({nm, "_loads"}, 32'(loads), 32'(NL));
    chk({nm, "_dones"}, 32'(dones), 32'd1);
    for (int i = 0; i < NL; i++) chk({nm, "_sel"}, 32'(sel_log[i]), 32'(exp_sel[i]));
    chk({nm, "_gap"}, 32'(gap_bad), 32'd0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          hold;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n;
    vecs[0] = '{32'h0000_0010, 1, 32'h0000_0014};
    vecs[1] = '{32'hFFFF_FFFE, 1, 32'h0000_0002};
    vecs[2] = '{32'h1234_0000, 3, 32'h1234_0004};
    vecs[3] = '{32'h0000_0000, 2, 32'h0000_0004};

    rst = 1'b1; start = 1'b0; abort = 1'b0; img_d = '0;
    #12;
    chk("reset_ctl", {25'd0, busy, done, layer_load, err, layer_sel}, 32'd0);
    chk("reset_buf", 32'(|result || |layer_d), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven complete runs
    foreach (vecs[v]) run_full("run", vecs[v].base, vecs[v].hold, vecs[v].exp_base);

    // start together with abort in IDLE: dropped
    clr_mon();
    img_d = mk(32'h5555_0000);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    chk("start_abort_loads", 32'(loads), 32'd0);
    chk_res("start_abort_buf", 32'h0000_0004);

    // start pulsed during WAIT of layer 2: ignored
    clr_mon();
    hold_n = 1;
    img_d = mk(32'h0000_0100);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(layer_load && layer_sel == L_CONV2) && n < BOUND) begin tick(); n++; end
    chk("mid_start_to", 32'(n < BOUND), 32'd1);
    tick();
    img_d = mk(32'h0000_9000);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("mid_start_done_to");
    chk_res("mid_start_result", 32'h0000_0104);
    tick();
    chk("mid_start_loads", 32'(loads), 32'(NL));
    chk("mid_start_dones", 32'(dones), 32'd1);

    // abort 2 cycles into WAIT of layer 1
    clr_mon();
    img_d = mk(32'h0000_0200);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(layer_load && layer_sel == L_POOL1) && n < BOUND) begin tick(); n++; end
    chk("abort_to", 32'(n < BOUND), 32'd1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (10) tick();
    chk("abort_dones", 32'(dones), 32'd0);
    chk("abort_loads", 32'(loads), 32'd2);
    chk_res("abort_buf_hold", 32'h0000_0201);
    run_full("rerun", 32'h0000_0300, 1, 32'h0000_0304);

    // reset in the middle of DRAIN
    clr_mon();
    hold_n = 3;
    img_d = mk(32'h0000_0400);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!layer_valid && n < BOUND) begin tick(); n++; end
    chk("rst_drain_to", 32'(n < BOUND), 32'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctl", {25'd0, busy, done, layer_load, err, layer_sel}, 32'd0);
    chk("rst_async_buf", 32'(|result || |layer_d), 32'd0);
    tick();
    rst = 1'b0;
    clr_mon();
    repeat (8) tick();
    chk("rst_stays_idle", {29'd0, busy, done, 1'b0} | 32'(loads), 32'd0);

`ifdef CNN_SEQ_TIMEOUT_EN
    // watchdog: WAIT lasts exactly TIMEOUT(=20) cycles, err follows
    clr_mon();
    never_valid = 1'b1;
    hold_n = 1;
    img_d = mk(32'h0000_0500);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("wd_wait20", {30'd0, busy, err}, 32'd2);
    tick();
    chk("wd_err", {30'd0, busy, err}, 32'd1);
    repeat (3) tick();
    chk("wd_err_sticky", {30'd0, err, done} | 32'(dones), 32'd2);
    never_valid = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("wd_err_clear", {30'd0, busy, err}, 32'd2);
    wait_done("wd_rerun_to");
    tick();
`else
    chk("err_tied", {31'd0, err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
